// File: rtl/ifu_iccm_dma_arb.sv
// ifu_iccm_dma_arb
//   Arbitrates the single ICCM port between the fetch pipe and DMA slave
//   requests. Fetch owns the port by default; a DMA request is granted
//   combinationally in any cycle the fetch controller reports
//   ifc_dma_access_ok. A DMA request that waits STARVE_MAX cycles raises
//   dma_iccm_stall_any to stall fetch, then gets up to BURST_MAX grants
//   before fetch is released again.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   dma_iccm_req/wr/addr/wdata/tag   DMA request, held until granted
//   ifc_dma_access_ok   fetch is not using the ICCM this cycle
//   dma_iccm_gnt        DMA access is performed this cycle
//   dma_iccm_stall_any  forces the fetch pipe to stall (registered)
//   iccm_dma_sel        ICCM port owned by DMA this cycle (= gnt)
//   iccm_wren/rden      ICCM write/read enable
//   iccm_addr           DMA address while selected, else 0
//   iccm_wr_data        write data during writes, else 0
//   dma_iccm_rvalid     read data valid at the DMA side, RD_LAT after grant
//   dma_iccm_rtag       tag returned with rvalid
//   dma_starved         PMU event: high in every WAIT or FORCE cycle
module ifu_iccm_dma_arb #(
    parameter int ICCM_AW    = 16,
    parameter int STARVE_MAX = 15,
    parameter int BURST_MAX  = 4,
    parameter int RD_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dma_iccm_req,
    input  logic               dma_iccm_wr,
    input  logic [ICCM_AW-1:0] dma_iccm_addr,
    input  logic [63:0]        dma_iccm_wdata,
    input  logic [2:0]         dma_iccm_tag,
    input  logic               ifc_dma_access_ok,
    output logic               dma_iccm_gnt,
    output logic               dma_iccm_stall_any,
    output logic               iccm_dma_sel,
    output logic               iccm_wren,
    output logic               iccm_rden,
    output logic [ICCM_AW-1:0] iccm_addr,
    output logic [63:0]        iccm_wr_data,
    output logic               dma_iccm_rvalid,
    output logic [2:0]         dma_iccm_rtag,
    output logic               dma_starved
);

    localparam int            SW        = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [3:0]    BURST_LIM  = 4'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_cnt_nxt;
    logic [3:0]    burst_cnt, burst_cnt_nxt;
    logic          stall_q;
    logic          req_ok;
    logic          gnt;

    logic          pipe_vld [RD_LAT];
    logic [2:0]    pipe_tag [RD_LAT];

    assign req_ok = dma_iccm_req & ifc_dma_access_ok;
    // Gated by rst so every output is 0 while reset is held.
    assign gnt    = req_ok & ~rst;

    // ------------------------------------------------------------------
    // ICCM port drive
    // ------------------------------------------------------------------
    assign dma_iccm_gnt       = gnt;
    assign iccm_dma_sel       = gnt;
    assign iccm_wren          = gnt & dma_iccm_wr;
    assign iccm_rden          = gnt & ~dma_iccm_wr;
    assign iccm_addr          = gnt ? dma_iccm_addr : '0;
    assign iccm_wr_data       = iccm_wren ? dma_iccm_wdata : '0;
    assign dma_iccm_stall_any = stall_q;
    assign dma_starved        = (state != IDLE);

    // ------------------------------------------------------------------
    // Starvation FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        burst_cnt_nxt  = burst_cnt;
        unique case (state)
            IDLE: begin
                if (dma_iccm_req && !ifc_dma_access_ok) begin
                    state_nxt      = WAIT;
                    starve_cnt_nxt = SW'(1);
                end
            end
            WAIT: begin
                // A grant wins over reaching the starvation limit.
                if (req_ok || !dma_iccm_req) begin
                    state_nxt      = IDLE;
                    starve_cnt_nxt = '0;
                end else if (starve_cnt == STARVE_LIM) begin
                    state_nxt     = FORCE;
                    burst_cnt_nxt = '0;
                end else begin
                    starve_cnt_nxt = starve_cnt + SW'(1);
                end
            end
            FORCE: begin
                if (req_ok) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                    if (burst_cnt + 4'd1 == BURST_LIM) begin
                        state_nxt      = IDLE;
                        starve_cnt_nxt = '0;
                    end
                end else if (!dma_iccm_req) begin
                    state_nxt      = IDLE;
                    starve_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                starve_cnt_nxt = '0;
                burst_cnt_nxt  = '0;
            end
        endcase
    end

    // Stall comes straight from a flop so fetch sees a glitch-free signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            stall_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            burst_cnt  <= burst_cnt_nxt;
            stall_q    <= (state_nxt == FORCE);
        end
    end

    // ------------------------------------------------------------------
    // Read return pipe: fully pipelined, independent of the FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pipe is reset so in-flight responses are dropped on reset.
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= iccm_rden;
            pipe_tag[0] <= dma_iccm_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign dma_iccm_rvalid = pipe_vld[RD_LAT-1];
    assign dma_iccm_rtag   = pipe_tag[RD_LAT-1];

endmodule

// File: tb/tb_ifu_iccm_dma_arb.sv
// tb_ifu_iccm_dma_arb
//   Scenario tasks drive the arbiter with inputs changed 1 ns after the
//   rising edge and outputs sampled on the falling edge. Expected read
//   returns go into a scoreboard queue when the read is driven; a monitor
//   pops and compares them when rvalid shows up.
module tb_ifu_iccm_dma_arb;

    localparam int AW   = 16;
    localparam int SMAX = 15;
    localparam int BMAX = 4;
    localparam int RDL  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dma_iccm_req = 1'b0;
    logic          dma_iccm_wr = 1'b0;
    logic [AW-1:0] dma_iccm_addr = '0;
    logic [63:0]   dma_iccm_wdata = '0;
    logic [2:0]    dma_iccm_tag = '0;
    logic          ifc_dma_access_ok = 1'b0;
    logic          dma_iccm_gnt, dma_iccm_stall_any, iccm_dma_sel;
    logic          iccm_wren, iccm_rden, dma_iccm_rvalid, dma_starved;
    logic [AW-1:0] iccm_addr;
    logic [63:0]   iccm_wr_data;
    logic [2:0]    dma_iccm_rtag;

    typedef struct {
        int         due;
        logic [2:0] tag;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      cyc      = 0;
    int      n_checks = 0;
    int      n_fail   = 0;

    ifu_iccm_dma_arb #(
        .ICCM_AW(AW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst),
        .dma_iccm_req(dma_iccm_req), .dma_iccm_wr(dma_iccm_wr),
        .dma_iccm_addr(dma_iccm_addr), .dma_iccm_wdata(dma_iccm_wdata),
        .dma_iccm_tag(dma_iccm_tag), .ifc_dma_access_ok(ifc_dma_access_ok),
        .dma_iccm_gnt(dma_iccm_gnt), .dma_iccm_stall_any(dma_iccm_stall_any),
        .iccm_dma_sel(iccm_dma_sel), .iccm_wren(iccm_wren), .iccm_rden(iccm_rden),
        .iccm_addr(iccm_addr), .iccm_wr_data(iccm_wr_data),
        .dma_iccm_rvalid(dma_iccm_rvalid), .dma_iccm_rtag(dma_iccm_rtag),
        .dma_starved(dma_starved)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for read returns.
    always @(negedge clk) begin : rd_monitor
        logic       exp_v;
        logic [2:0] exp_tag;
        if (!rst) begin
            exp_v   = (sb.size() != 0) && (sb[0].due == cyc);
            exp_tag = exp_v ? sb[0].tag : 3'd0;
            if (dma_iccm_rvalid || exp_v) begin
                n_checks++;
                if (dma_iccm_rvalid !== exp_v || (exp_v && dma_iccm_rtag !== exp_tag)) begin
                    n_fail++;
                    $display("FAIL rd_return cyc=%0d: rvalid=%b rtag=%0d, expected rvalid=%b rtag=%0d",
                             cyc, dma_iccm_rvalid, dma_iccm_rtag, exp_v, exp_tag);
                end
                if (exp_v) void'(sb.pop_front());
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [AW-1:0] addr,
                         input logic [63:0] wd, input logic [2:0] tag, input logic ok);
        dma_iccm_req      = req;
        dma_iccm_wr       = wr;
        dma_iccm_addr     = addr;
        dma_iccm_wdata    = wd;
        dma_iccm_tag      = tag;
        ifc_dma_access_ok = ok;
    endtask

    task automatic push_read(input logic [2:0] tag);
        rd_exp_t e;
        e.due = cyc + RDL;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Holds a write request with ok low for n cycles, starting in IDLE.
    task automatic starve_run(input string name, input int n);
        for (int j = 0; j < n; j++) begin
            next_cycle();
            drive(1'b1, 1'b1, 16'h0300, 64'h55, 3'd0, 1'b0);
            @(negedge clk);
            n_checks++;
            if ({dma_iccm_gnt, dma_starved, dma_iccm_stall_any} !== {1'b0, j >= 1, j >= SMAX + 1}) begin
                n_fail++;
                $display("FAIL %s j=%0d: gnt/starved/stall=%b, expected %b", name, j,
                         {dma_iccm_gnt, dma_starved, dma_iccm_stall_any},
                         {1'b0, j >= 1, j >= SMAX + 1});
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            next_cycle();
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 16'h1234, 64'hAB, 3'd1, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, iccm_dma_sel, iccm_wren, iccm_rden,
             dma_iccm_rvalid, dma_starved, iccm_addr, iccm_wr_data, dma_iccm_rtag} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b sel=%b rden=%b addr=%h, expected all 0",
                     dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_addr);
        end
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, dma_starved} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: gnt/stall/starved=%b, expected 000",
                     {dma_iccm_gnt, dma_iccm_stall_any, dma_starved});
        end
    endtask

    task automatic test_single_access();
        idle_cycles(3);
        next_cycle();
        drive(1'b1, 1'b0, 16'h0100, 64'hDEAD_BEEF_0000_1111, 3'd5, 1'b1);
        push_read(3'd5);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren} !== 4'b1110 ||
            iccm_addr !== 16'h0100 || iccm_wr_data !== 64'h0) begin
            n_fail++;
            $display("FAIL single_read: gnt/sel/rden/wren=%b addr=%h wdata=%h, expected 1110 0100 0",
                     {dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren}, iccm_addr, iccm_wr_data);
        end
        next_cycle();
        drive(1'b1, 1'b1, 16'h0208, 64'hCAFE_F00D_1234_5678, 3'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren} !== 4'b1101 ||
            iccm_addr !== 16'h0208 || iccm_wr_data !== 64'hCAFE_F00D_1234_5678) begin
            n_fail++;
            $display("FAIL single_write: gnt/sel/rden/wren=%b addr=%h wdata=%h, expected 1101 0208 cafef00d12345678",
                     {dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren}, iccm_addr, iccm_wr_data);
        end
        next_cycle();
        drive(1'b0, 1'b1, 16'h0208, 64'hCAFE_F00D_1234_5678, 3'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren} !== 4'b0000 ||
            iccm_addr !== '0 || iccm_wr_data !== '0) begin
            n_fail++;
            $display("FAIL no_req_port: gnt/sel/rden/wren=%b addr=%h wdata=%h, expected all 0",
                     {dma_iccm_gnt, iccm_dma_sel, iccm_rden, iccm_wren}, iccm_addr, iccm_wr_data);
        end
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({dma_iccm_stall_any, dma_starved} !== 2'b00) begin
                n_fail++;
                $display("FAIL single_nostall j=%0d: stall/starved=%b, expected 00",
                         j, {dma_iccm_stall_any, dma_starved});
            end
        end
    endtask

    task automatic test_starve();
        starve_run("starve", SMAX + 2);
        next_cycle();
        drive(1'b1, 1'b1, 16'h0300, 64'h55, 3'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, dma_starved, iccm_wren} !== 4'b1111) begin
            n_fail++;
            $display("FAIL starve_grant: gnt/stall/starved/wren=%b, expected 1111",
                     {dma_iccm_gnt, dma_iccm_stall_any, dma_starved, iccm_wren});
        end
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any} !== 2'b01) begin
            n_fail++;
            $display("FAIL starve_withdraw_force: gnt/stall=%b, expected 01",
                     {dma_iccm_gnt, dma_iccm_stall_any});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_stall_any, dma_starved} !== 2'b00) begin
            n_fail++;
            $display("FAIL starve_release: stall/starved=%b, expected 00",
                     {dma_iccm_stall_any, dma_starved});
        end
    endtask

    task automatic test_burst();
        logic [AW-1:0] a;
        starve_run("burst_starve", SMAX + 1);
        for (int w = 0; w < BMAX; w++) begin
            a = AW'(16'h0400 + 8 * w);
            next_cycle();
            drive(1'b1, 1'b1, a, 64'(w + 100), 3'd0, 1'b1);
            @(negedge clk);
            n_checks++;
            if ({dma_iccm_gnt, dma_iccm_stall_any, iccm_wren} !== 3'b111 || iccm_addr !== a) begin
                n_fail++;
                $display("FAIL burst_grant w=%0d: gnt/stall/wren=%b addr=%h, expected 111 %h",
                         w, {dma_iccm_gnt, dma_iccm_stall_any, iccm_wren}, iccm_addr, a);
            end
        end
        // Burst exhausted: back to IDLE, fetch released.
        next_cycle();
        drive(1'b1, 1'b1, 16'h0420, 64'd104, 3'd0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, dma_starved} !== 3'b000) begin
            n_fail++;
            $display("FAIL burst_end: gnt/stall/starved=%b, expected 000",
                     {dma_iccm_gnt, dma_iccm_stall_any, dma_starved});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, dma_starved} !== 3'b001) begin
            n_fail++;
            $display("FAIL burst_rewait: gnt/stall/starved=%b, expected 001",
                     {dma_iccm_gnt, dma_iccm_stall_any, dma_starved});
        end
        for (int w = 4; w < 6; w++) begin
            a = AW'(16'h0400 + 8 * w);
            next_cycle();
            drive(1'b1, 1'b1, a, 64'(w + 100), 3'd0, 1'b1);
            @(negedge clk);
            n_checks++;
            if ({dma_iccm_gnt, dma_iccm_stall_any} !== 2'b10 || iccm_addr !== a ||
                iccm_wr_data !== 64'(w + 100)) begin
                n_fail++;
                $display("FAIL burst_natural w=%0d: gnt/stall=%b addr=%h wdata=%0d, expected 10 %h %0d",
                         w, {dma_iccm_gnt, dma_iccm_stall_any}, iccm_addr, iccm_wr_data, a, w + 100);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_tie();
        starve_run("tie_starve", SMAX);
        next_cycle();
        drive(1'b1, 1'b0, 16'h0500, 64'h0, 3'd6, 1'b1);
        push_read(3'd6);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, dma_iccm_stall_any, dma_starved, iccm_rden} !== 4'b1011) begin
            n_fail++;
            $display("FAIL tie_grant: gnt/stall/starved/rden=%b, expected 1011",
                     {dma_iccm_gnt, dma_iccm_stall_any, dma_starved, iccm_rden});
        end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0508, 64'h0, 3'd7, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_stall_any, dma_starved} !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_idle: stall/starved=%b, expected 00 (IDLE not FORCE)",
                     {dma_iccm_stall_any, dma_starved});
        end
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_stall_any, dma_starved} !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_wait: stall/starved=%b, expected 01",
                     {dma_iccm_stall_any, dma_starved});
        end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive(1'b1, 1'b0, 16'h0600, 64'h0, 3'd1, 1'b1);
        push_read(3'd1);
        next_cycle();
        drive(1'b1, 1'b0, 16'h0608, 64'h0, 3'd2, 1'b1);
        push_read(3'd2);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_gnt, iccm_rden} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_second_grant: gnt/rden=%b, expected 11", {dma_iccm_gnt, iccm_rden});
        end
        idle_cycles(4);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drained: %0d reads outstanding, expected 0", sb.size());
        end
        // Reset while a read is in flight.
        next_cycle();
        drive(1'b1, 1'b0, 16'h0610, 64'h0, 3'd3, 1'b1);
        next_cycle();
        rst = 1'b1;
        sb.delete();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if ({dma_iccm_gnt, dma_iccm_stall_any, iccm_dma_sel, iccm_wren, iccm_rden,
                 dma_iccm_rvalid, dma_starved, iccm_addr, iccm_wr_data, dma_iccm_rtag} !== '0) begin
                n_fail++;
                $display("FAIL rst_midflight j=%0d: gnt=%b rden=%b rvalid=%b rtag=%0d, expected all 0",
                         j, dma_iccm_gnt, iccm_rden, dma_iccm_rvalid, dma_iccm_rtag);
            end
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (dma_iccm_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_dropped j=%0d: rvalid=%b, expected 0", j, dma_iccm_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_withdraw();
        starve_run("withdraw_starve", 7);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_stall_any, dma_starved} !== 2'b01) begin
            n_fail++;
            $display("FAIL withdraw_in_wait: stall/starved=%b, expected 01",
                     {dma_iccm_stall_any, dma_starved});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({dma_iccm_stall_any, dma_starved} !== 2'b00) begin
            n_fail++;
            $display("FAIL withdraw_idle: stall/starved=%b, expected 00",
                     {dma_iccm_stall_any, dma_starved});
        end
        // Counter restarts from 1: FORCE only after a full new interval.
        starve_run("restarve", SMAX + 2);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (dma_iccm_stall_any !== 1'b1) begin
            n_fail++;
            $display("FAIL restarve_force_hold: stall=%b, expected 1", dma_iccm_stall_any);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (dma_iccm_stall_any !== 1'b0) begin
            n_fail++;
            $display("FAIL restarve_release: stall=%b, expected 0", dma_iccm_stall_any);
        end
    endtask

    initial begin
        test_reset();
        test_single_access();
        test_starve();
        test_burst();
        test_tie();
        test_back_to_back();
        test_withdraw();
        idle_cycles(4);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d reads outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
